// File: rtl/inst_feeder.sv
// Instruction feeder: preloaded word store streamed to a CPU by fetch address, with retire tracking and abort codes.
// Optional macro INST_FEEDER_ADDR_CHECK_EN enables misaligned/out-of-range fetch faults (code 4).
module inst_feeder #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int DEPTH    = 256,
  parameter int EXEC_NUM = 140,
  parameter int MAX_LAT  = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [DATA_W-1:0]        load_data,
  input  logic [ADDR_W-1:0]        cpu_inst_addr,
  input  logic                     cpu_out_valid,
  output logic                     in_valid,
  output logic [DATA_W-1:0]        inst,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [2:0]               err_code,
  output logic [15:0]              retired_cnt
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [15:0] EXEC_N1 = 16'(EXEC_NUM - 1);
  localparam logic [15:0] LAT_N   = 16'(MAX_LAT);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE, S_ERR} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [15:0]         r_issue_cnt;
  logic [15:0]         r_lat_cnt;
  logic [AW-1:0]       w_idx;
  logic                w_addr_fault;
  logic                w_issue;
  logic                w_start;
  logic [2:0]          w_code_nxt;

  assign w_idx = cpu_inst_addr[AW+1:2];

`ifdef INST_FEEDER_ADDR_CHECK_EN
  assign w_addr_fault = (cpu_inst_addr[1:0] != 2'b00) ||
                        ((cpu_inst_addr >> (AW + 2)) != '0);
`else
  logic w_unused_addr;
  assign w_unused_addr = &{1'b0, cpu_inst_addr};
  assign w_addr_fault  = 1'b0;
`endif

  assign busy = (r_state == S_ISSUE) || (r_state == S_DRAIN);
  assign done = (r_state == S_DONE);
  assign err  = (r_state == S_ERR);

  always_comb begin
    w_state_nxt = r_state;
    w_code_nxt  = 3'd0;
    w_issue     = 1'b0;
    w_start     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !load_en) begin
          w_state_nxt = S_ISSUE;
          w_start     = 1'b1;
        end
      end
      S_DONE: begin
        // A retire after completion is a CPU fault and outranks a new run request.
        if (cpu_out_valid) begin
          w_state_nxt = S_ERR;
          w_code_nxt  = 3'd3;
        end else if (start && !load_en) begin
          w_state_nxt = S_ISSUE;
          w_start     = 1'b1;
        end
      end
      S_ISSUE, S_DRAIN: begin
        if (cpu_out_valid && (retired_cnt == EXEC_N1)) begin
          w_state_nxt = S_DONE;
        end else if (!cpu_out_valid && (retired_cnt == '0) && (r_lat_cnt + 16'd1 >= LAT_N)) begin
          w_state_nxt = S_ERR;
          w_code_nxt  = 3'd1;
        end else if (!cpu_out_valid && (retired_cnt != '0)) begin
          w_state_nxt = S_ERR;
          w_code_nxt  = 3'd2;
        end else if ((r_state == S_ISSUE) && w_addr_fault) begin
          w_state_nxt = S_ERR;
          w_code_nxt  = 3'd4;
        end else if (r_state == S_ISSUE) begin
          w_issue = 1'b1;
          if (r_issue_cnt == EXEC_N1) w_state_nxt = S_DRAIN;
        end
      end
      default: w_state_nxt = r_state;
    endcase
  end

  // Store has no reset so a run can be repeated after rst without reloading.
  always_ff @(posedge clk) begin
    if (load_en && ((r_state == S_IDLE) || (r_state == S_DONE)))
      r_mem[load_addr] <= load_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      in_valid    <= 1'b0;
      inst        <= '0;
      err_code    <= 3'd0;
      retired_cnt <= '0;
      r_issue_cnt <= '0;
      r_lat_cnt   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      in_valid <= w_issue;
      inst     <= w_issue ? r_mem[w_idx] : '0;
      if ((w_state_nxt == S_ERR) && (r_state != S_ERR))
        err_code <= w_code_nxt;
      if (w_start) begin
        retired_cnt <= '0;
        r_issue_cnt <= '0;
        r_lat_cnt   <= '0;
      end else if (busy) begin
        if (w_issue)                            r_issue_cnt <= r_issue_cnt + 16'd1;
        if (cpu_out_valid)                      retired_cnt <= retired_cnt + 16'd1;
        if (!cpu_out_valid && retired_cnt == '0) r_lat_cnt  <= r_lat_cnt + 16'd1;
      end
    end
  end

endmodule
